// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Converts a byte-wide command stream into single Wishbone classic cycles and
// returns a one-byte response for every frame.
//
//   write frame : 0x57 'W', ADDR, DATA  -> response 0x06 (ACK) or 0x15 (NAK)
//   read  frame : 0x52 'R', ADDR        -> response read data or 0x15 (NAK)
//   other byte  : no bus cycle          -> response 0x15 (NAK)
//
// A bus cycle that sees no ack is abandoned after TIMEOUT cycles of wb_cyc_o
// and answered with NAK. Only ADDR[ADDR_WIDTH-1:0] reaches the bus.
//
// Parameters
//   ADDR_WIDTH  Wishbone address width (1..8)
//   TIMEOUT     maximum cycles wb_cyc_o stays high without ack (2..255)
//
// Ports
//   wb_clk_in    in   clock, rising edge
//   wb_rst_in    in   synchronous reset, active-high
//   rx_data_in   in   [7:0] command stream byte
//   rx_valid_in  in   command byte valid
//   rx_ready_o   out  block accepts a command byte this cycle
//   tx_data_o    out  [7:0] response byte
//   tx_valid_o   out  response byte valid
//   tx_ready_in  in   downstream accepts the response byte
//   wb_adr_o     out  [ADDR_WIDTH-1:0] Wishbone address
//   wb_dat_o     out  [7:0] Wishbone write data
//   wb_we_o      out  write enable
//   wb_cyc_o     out  cycle
//   wb_stb_o     out  strobe
//   wb_ack_in    in   slave acknowledge
//   wb_dat_in    in   [7:0] Wishbone read data
// -----------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  wb_clk_in,
  input  logic                  wb_rst_in,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_in,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [7:0]            wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_in,
  input  logic [7:0]            wb_dat_in
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  // Counter value at the edge that closes a TIMEOUT-cycle bus window.
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WB_CYCLE,
    ST_RESPOND
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [7:0]            r_cnt;

  logic w_rx_fire;
  logic w_tx_fire;

  assign w_rx_fire = rx_valid_in & rx_ready_o;
  assign w_tx_fire = tx_valid_o & tx_ready_in;

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_adr      <= '0;
      r_cnt      <= 8'd0;
      rx_ready_o <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Also the first edge after reset release: open the rx stream.
          rx_ready_o <= 1'b1;
          if (w_rx_fire) begin
            if (rx_data_in == CMD_WRITE) begin
              r_write <= 1'b1;
              r_state <= ST_GET_ADDR;
            end else if (rx_data_in == CMD_READ) begin
              r_write <= 1'b0;
              r_state <= ST_GET_ADDR;
            end else begin
              // Unknown command: answer NAK without touching the bus.
              rx_ready_o <= 1'b0;
              tx_data_o  <= RSP_NAK;
              tx_valid_o <= 1'b1;
              r_state    <= ST_RESPOND;
            end
          end
        end

        ST_GET_ADDR: begin
          if (w_rx_fire) begin
            if (r_write) begin
              // Address is parked until the data byte so the bus address
              // only changes when the cycle actually starts.
              r_adr   <= rx_data_in[ADDR_WIDTH-1:0];
              r_state <= ST_GET_DATA;
            end else begin
              rx_ready_o <= 1'b0;
              wb_adr_o   <= rx_data_in[ADDR_WIDTH-1:0];
              wb_we_o    <= 1'b0;
              wb_cyc_o   <= 1'b1;
              wb_stb_o   <= 1'b1;
              r_cnt      <= 8'd0;
              r_state    <= ST_WB_CYCLE;
            end
          end
        end

        ST_GET_DATA: begin
          if (w_rx_fire) begin
            rx_ready_o <= 1'b0;
            wb_adr_o   <= r_adr;
            wb_dat_o   <= rx_data_in;
            wb_we_o    <= 1'b1;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= ST_WB_CYCLE;
          end
        end

        ST_WB_CYCLE: begin
          // Ack is tested first so it wins on the terminal edge.
          if (wb_ack_in) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            tx_data_o  <= wb_we_o ? RSP_ACK : wb_dat_in;
            tx_valid_o <= 1'b1;
            r_state    <= ST_RESPOND;
          end else if (r_cnt == CNT_LAST) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            tx_data_o  <= RSP_NAK;
            tx_valid_o <= 1'b1;
            r_state    <= ST_RESPOND;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_RESPOND: begin
          if (w_tx_fire) begin
            tx_valid_o <= 1'b0;
            rx_ready_o <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          rx_ready_o <= 1'b0;
          tx_valid_o <= 1'b0;
          wb_cyc_o   <= 1'b0;
          wb_stb_o   <= 1'b0;
          wb_we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Directed and randomized frames against a Wishbone memory slave with a
// programmable ack latency. Expected responses, bus-cycle counts, cycle
// lengths and memory contents come from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int AW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data_in;
  logic          rx_valid_in;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_in;
  logic [AW-1:0] wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_in;
  logic [7:0]    wb_dat_in;

  wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_in  (clk),
    .wb_rst_in  (rst),
    .rx_data_in (rx_data_in),
    .rx_valid_in(rx_valid_in),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_in(tx_ready_in),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_in  (wb_ack_in),
    .wb_dat_in  (wb_dat_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [7:0] mem [DEPTH];
  logic       mem_clr;
  int         slv_lat;
  int         slv_wait;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wb_cyc_o && wb_stb_o && wb_ack_in && wb_we_o) begin
      mem[wb_adr_o] <= wb_dat_o;
    end
  end

  // Ack is raised after slv_lat idle cycles of an active strobe.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (slv_wait >= slv_lat) begin
        wb_ack_in = 1'b1;
        wb_dat_in = mem[wb_adr_o];
      end else begin
        wb_ack_in = 1'b0;
        slv_wait  = slv_wait + 1;
      end
    end else begin
      wb_ack_in = 1'b0;
      slv_wait  = 0;
    end
  end

  // ---------------- bus monitor ----------------
  int            n_cycles;
  int            cyc_len;
  int            unstable;
  int            stb_bad;
  int            rx_bad;
  logic          prev_cyc;
  logic [AW-1:0] cap_adr;
  logic          cap_we;
  logic [7:0]    cap_dat;

  always @(negedge clk) begin
    if (wb_stb_o && !wb_cyc_o) stb_bad = stb_bad + 1;
    if (wb_cyc_o && rx_ready_o) rx_bad = rx_bad + 1;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        n_cycles = n_cycles + 1;
        cyc_len  = 0;
        cap_adr  = wb_adr_o;
        cap_we   = wb_we_o;
        cap_dat  = wb_dat_o;
      end else if (wb_adr_o !== cap_adr || wb_we_o !== cap_we || wb_dat_o !== cap_dat) begin
        unstable = unstable + 1;
      end
      cyc_len = cyc_len + 1;
    end
    prev_cyc = wb_cyc_o;
  end

  // ---------------- checking ----------------
  int         errors;
  int         checks;
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] last_wdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input string tag, input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data_in  = b;
    rx_valid_in = 1'b1;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) chk({tag, ".rx_ready_wait"}, rx_ready_o, 1);
    @(posedge clk);
    #1;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'($urandom);
    @(negedge clk);
  endtask

  // One whole frame: stimulus, reference prediction, and checks.
  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [7:0] adr,
                          input logic [7:0] dat, input int lat, input int hold,
                          output logic [7:0] got);
    bit         isw, isr, acked;
    int         idx, c0, n, exp_ncyc, exp_len;
    logic [7:0] exp_rsp;
    isw     = (cmd == 8'h57);
    isr     = (cmd == 8'h52);
    idx     = int'(adr) % DEPTH;
    acked   = (lat < TIMEOUT);
    slv_lat = lat;
    c0      = n_cycles;
    exp_len = 0;

    send_byte({tag, ".cmd"}, cmd);
    if (isw || isr) send_byte({tag, ".adr"}, adr);
    if (isw) send_byte({tag, ".dat"}, dat);

    if (!(isw || isr)) begin
      exp_rsp  = 8'h15;
      exp_ncyc = 0;
    end else begin
      exp_ncyc = 1;
      exp_len  = acked ? lat + 1 : TIMEOUT;
      if (isw) begin
        exp_rsp = acked ? 8'h06 : 8'h15;
        if (acked) exp_mem[idx] = dat;
      end else begin
        exp_rsp = acked ? exp_mem[idx] : 8'h15;
      end
    end

    n = 0;
    while (!tx_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    got = tx_data_o;
    chk({tag, ".tx_valid"}, tx_valid_o, 1);
    chk({tag, ".tx_data"}, tx_data_o, exp_rsp);
    chk({tag, ".n_bus_cycles"}, n_cycles - c0, exp_ncyc);
    if (exp_ncyc == 1) begin
      chk({tag, ".cyc_len"}, cyc_len, exp_len);
      chk({tag, ".adr"}, cap_adr, idx);
      chk({tag, ".we"}, cap_we, isw);
      chk({tag, ".wdat"}, cap_dat, isw ? dat : last_wdat);
      chk({tag, ".bus_stable"}, unstable, 0);
    end
    if (isw) begin
      last_wdat = dat;
      chk({tag, ".mem"}, mem[idx], exp_mem[idx]);
    end

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, tx_valid_o, 1);
      chk({tag, ".hold_data"}, tx_data_o, exp_rsp);
      chk({tag, ".hold_rx_ready"}, rx_ready_o, 0);
    end
    tx_ready_in = 1'b1;
    @(posedge clk);
    #1;
    tx_ready_in = 1'b0;
    chk({tag, ".tx_done"}, tx_valid_o, 0);
    chk({tag, ".rx_reopen"}, rx_ready_o, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, cmd, adr, dat;
    int         lat, n, r;
    errors = 0; checks = 0;
    n_cycles = 0; cyc_len = 0; unstable = 0; stb_bad = 0; rx_bad = 0;
    prev_cyc = 1'b0; slv_wait = 0; slv_lat = 0;
    wb_ack_in = 1'b0; wb_dat_in = 8'h00;
    rx_data_in = 8'h00; rx_valid_in = 1'b0; tx_ready_in = 1'b0;
    last_wdat = 8'h00;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;

    // Reset state
    rst = 1'b1; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk("rst.rx_ready", rx_ready_o, 0);
    chk("rst.tx_valid", tx_valid_o, 0);
    chk("rst.tx_data", tx_data_o, 8'h00);
    chk("rst.cyc", wb_cyc_o, 0);
    chk("rst.stb", wb_stb_o, 0);
    chk("rst.we", wb_we_o, 0);
    chk("rst.adr", wb_adr_o, 0);
    chk("rst.dat", wb_dat_o, 8'h00);
    rst = 1'b0;
    chk("rel.rx_ready_before_edge", rx_ready_o, 0);
    @(posedge clk);
    #1;
    chk("rel.rx_ready_after_edge", rx_ready_o, 1);
    @(negedge clk);

    // Write, then preload and read back through the ignored upper address bits
    do_frame("wr", 8'h57, 8'h03, 8'h5A, 0, 0, got);
    chk("wr.resp_const", got, 8'h06);
    chk("wr.mem3_const", mem[3], 8'h5A);
    do_frame("wr_pre", 8'h57, 8'h03, 8'hA5, 1, 0, got);
    do_frame("rd", 8'h52, 8'h13, 8'h00, 0, 0, got);
    chk("rd.resp_const", got, 8'hA5);

    // Bad command, then a normal frame
    do_frame("bad", 8'h41, 8'h00, 8'h00, 0, 0, got);
    chk("bad.resp_const", got, 8'h15);
    do_frame("bad_next", 8'h52, 8'h00, 8'h00, 0, 0, got);

    // Timeout, then ack on the terminal edge
    do_frame("to", 8'h52, 8'h02, 8'h00, NEVER, 0, got);
    chk("to.len_const", cyc_len, 15);
    chk("to.resp_const", got, 8'h15);
    do_frame("to_ack15", 8'h57, 8'h02, 8'hC3, 0, 0, got);
    do_frame("to_ack15_rd", 8'h52, 8'h02, 8'h00, TIMEOUT - 1, 0, got);
    chk("to_ack15.resp_const", got, 8'hC3);

    // Backpressure
    do_frame("bp", 8'h52, 8'h03, 8'h00, 2, 5, got);

    // Reset during a bus cycle
    slv_lat = NEVER;
    send_byte("rstcyc.cmd", 8'h52);
    send_byte("rstcyc.adr", 8'h05);
    n = 0;
    while (!wb_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstcyc.cyc_up", wb_cyc_o, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstcyc.cyc", wb_cyc_o, 0);
    chk("rstcyc.stb", wb_stb_o, 0);
    chk("rstcyc.tx_valid", tx_valid_o, 0);
    chk("rstcyc.dat", wb_dat_o, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    last_wdat = 8'h00;
    @(negedge clk);
    do_frame("rstcyc_rd", 8'h52, 8'h03, 8'h00, 0, 0, got);
    chk("rstcyc_rd.resp_const", got, 8'hA5);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cmd = 8'($urandom);
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
      end else if (r < 5) begin
        cmd = 8'h57;
      end else begin
        cmd = 8'h52;
      end
      adr = 8'($urandom);
      dat = 8'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)      lat = TIMEOUT - 1;
      else if (r == 1) lat = TIMEOUT;
      else if (r == 2) lat = NEVER;
      else             lat = $urandom_range(0, 3);
      do_frame($sformatf("rnd%0d", t), cmd, adr, dat, lat, $urandom_range(0, 3), got);
    end

    chk("stb_without_cyc", stb_bad, 0);
    chk("rx_ready_during_cyc", rx_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning Wishbone address width (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles wb_cyc_o stays high without an ack (2..255).
REQ-003 SHALL have port wb_clk_in  input  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_in  input  1  synchronous reset, active-high.
REQ-005 SHALL have port rx_data_in  input  8  command stream byte.
REQ-006 SHALL have port rx_valid_in  input  1  rx_data_in is valid.
REQ-007 SHALL have port rx_ready_o  output  1  the block accepts a byte this cycle.
REQ-008 SHALL have port tx_data_o  output  8  response byte.
REQ-009 SHALL have port tx_valid_o  output  1  tx_data_o is valid.
REQ-010 SHALL have port tx_ready_in  input  1  the downstream sink accepts the byte.
REQ-011 SHALL have port wb_adr_o  output  ADDR_WIDTH  Wishbone address.
REQ-012 SHALL have port wb_dat_o  output  8  Wishbone write data (master to slave).
REQ-013 SHALL have port wb_we_o  output  1  write enable.
REQ-014 SHALL have port wb_cyc_o  output  1  cycle.
REQ-015 SHALL have port wb_stb_o  output  1  strobe.
REQ-016 SHALL have port wb_ack_in  input  1  slave acknowledge.
REQ-017 SHALL have port wb_dat_in  input  8  Wishbone read data (slave to master).

Function
REQ-018 SHALL transfer a byte on a rising edge only when valid and ready are both high at that edge, on both the rx and tx streams.
REQ-019 SHALL implement the frame formats: write = 0x57 ('W'), ADDR, DATA; read = 0x52 ('R'), ADDR.
REQ-020 SHALL use only ADDR[ADDR_WIDTH-1:0] and ignore the upper address bits.
REQ-021 SHALL implement the states IDLE, GET_ADDR, GET_DATA, WB_CYCLE and RESPOND; all outputs are registered.
REQ-022 SHALL drive rx_ready_o high exactly in IDLE, GET_ADDR and GET_DATA, and low in WB_CYCLE and RESPOND.
REQ-023 SHALL make these IDLE transitions on a command byte: 0x57 -> GET_ADDR with the write flag set; 0x52 -> GET_ADDR with the write flag clear; any other byte -> RESPOND with response 0x15 (NAK) and no bus cycle.
REQ-024 SHALL make these GET_ADDR transitions on the address byte: write -> GET_DATA; read -> WB_CYCLE.
REQ-025 SHALL move from GET_DATA to WB_CYCLE on the data byte.
REQ-026 SHALL wait indefinitely between bytes (no inter-byte timeout).
REQ-027 SHALL, at the edge that accepts the last frame byte, set wb_cyc_o=wb_stb_o=1 and load wb_adr_o and wb_we_o (plus wb_dat_o for writes), holding them stable until the cycle ends.
REQ-028 SHALL, for a read, hold wb_dat_o at its previous value.
REQ-029 SHALL sample wb_ack_in at each edge while wb_cyc_o=1.
REQ-030 SHALL, at the first edge with ack=1, clear wb_cyc_o, wb_stb_o and wb_we_o, enter RESPOND, and load tx_data_o (read: wb_dat_in captured at that edge; write: 0x06 ACK).
REQ-031 SHALL clear the timeout counter on entry to WB_CYCLE and increment it at each edge where wb_cyc_o=1 and ack=0.
REQ-032 SHALL abort at the edge where the counter equals TIMEOUT-1 and ack=0: clear cyc/stb/we, tx_data_o=0x15, enter RESPOND, so that wb_cyc_o is high for exactly TIMEOUT cycles.
REQ-033 SHALL give ack priority over timeout when ack arrives on the terminal edge.
REQ-034 SHALL set tx_valid_o high on entry to RESPOND and hold tx_data_o stable until tx_ready_in=1.
REQ-035 SHALL, at the transfer edge, clear tx_valid_o and enter IDLE.
REQ-036 SHALL permit back-to-back frames: after a single intervening cycle, rx_ready_o is high again.
REQ-037 SHALL issue exactly one Wishbone cycle per valid frame and never assert wb_stb_o without wb_cyc_o.

Reset
REQ-038 SHALL, at each edge while wb_rst_in=1, set state=IDLE, rx_ready_o=0, tx_valid_o=0, tx_data_o=0x00, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0x00 and the counter to 0.
REQ-039 SHALL set rx_ready_o=1 at the first edge after wb_rst_in falls.
REQ-040 SHALL give reset priority over everything, including mid-frame, mid-bus-cycle and pending tx: the partial frame is discarded and wb_cyc_o drops at the reset edge.

Verification
REQ-041 SHALL be verified with a write test: rx 0x57,0x03,0x5A against a single-cycle-ack slave -> one cycle with adr=3, dat=0x5A, we=1; tx 0x06; slave location 3 = 0x5A.
REQ-042 SHALL be verified with a read test: location 3 preloaded 0xA5; rx 0x52,0x13 (ADDR_WIDTH=4) -> read cycle adr=3, we=0; tx 0xA5.
REQ-043 SHALL be verified with a bad-command test: rx 0x41 -> tx 0x15; wb_cyc_o never high; next frame 0x52,0x00 is serviced normally.
REQ-044 SHALL be verified with a timeout test: slave never acks; rx 0x52,0x02 -> wb_cyc_o high exactly 15 cycles, then tx 0x15; an ack on the 15th edge instead yields read data.
REQ-045 SHALL be verified with a backpressure test: tx_ready_in low for 5 cycles after a read -> tx_valid_o stays high, tx_data_o is unchanged, and rx_ready_o stays low throughout.
REQ-046 SHALL be verified with a reset-mid-cycle test: reset asserted while wb_cyc_o=1 -> at that edge cyc/stb=0 and tx_valid_o=0; after release a 0x52,0x03 frame returns the correct data.
